// File: rtl/ahb_sram_responder.sv
// AHB-Lite SRAM responder: word-organised memory with byte/halfword/word lanes,
// programmable OKAY wait states and a two-cycle ERROR response for bad transfers.
module ahb_sram_responder #(
  parameter int ADDR_W      = 12,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hsel,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [1:0]        htrans,
  input  logic [2:0]        hsize,
  input  logic              hwrite,
  input  logic              hready,
  input  logic [31:0]       hwdata,
  output logic              hreadyout,
  output logic              hresp,
  output logic [31:0]       hrdata
);

  localparam int MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_ERR1 = 3'd3;
  localparam logic [2:0] ST_ERR2 = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [MEM_AW-1:0] wordIdx_q, wordIdx_d;
  logic [1:0]        lane_q, lane_d;
  logic [1:0]        size_q, size_d;
  logic              write_q, write_d;

  logic [31:0] mem_q [MEM_DEPTH];

  logic        accept;
  logic        illegal;
  logic [31:0] wordAddr;
  logic [3:0]  byteEn;
  logic        commit;

  assign accept   = hsel & hready & htrans[1];
  assign wordAddr = 32'(haddr[ADDR_W-1:2]);
  assign illegal  = (hsize > 3'd2)
                  | ((hsize == 3'd1) & haddr[0])
                  | ((hsize == 3'd2) & (haddr[1:0] != 2'b00))
                  | (wordAddr >= 32'(MEM_DEPTH));

  // New addresses are only taken when the previous data phase is finishing (or idle).
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wordIdx_d = wordIdx_q;
    lane_d    = lane_q;
    size_d    = size_q;
    write_d   = write_q;
    case (state_q)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        if (accept) begin
          wordIdx_d = haddr[MEM_AW+1:2];
          lane_d    = haddr[1:0];
          size_d    = hsize[1:0];
          write_d   = hwrite;
          if (illegal) begin
            state_d = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = 4'(WAIT_STATES);
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = ST_DATA;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      wordIdx_q <= '0;
      lane_q    <= 2'd0;
      size_q    <= 2'd0;
      write_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wordIdx_q <= wordIdx_d;
      lane_q    <= lane_d;
      size_q    <= size_d;
      write_q   <= write_d;
    end
  end

  // Little-endian lane selection from the registered address/size.
  always_comb begin
    case (size_q)
      2'd0:    byteEn = 4'b0001 << lane_q;
      2'd1:    byteEn = lane_q[1] ? 4'b1100 : 4'b0011;
      default: byteEn = 4'b1111;
    endcase
  end

  assign commit = (state_q == ST_DATA) & write_q & ~reset;

  always_ff @(posedge clk) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (byteEn[b]) mem_q[wordIdx_q][8*b +: 8] <= hwdata[8*b +: 8];
      end
    end
  end

  assign hreadyout = ~((state_q == ST_WAIT) | (state_q == ST_ERR1));
  assign hresp     = (state_q == ST_ERR1) | (state_q == ST_ERR2);
  assign hrdata    = ((state_q == ST_DATA) & ~write_q) ? mem_q[wordIdx_q] : 32'd0;

endmodule

// File: tb/tb_ahb_sram_responder.sv
// Bench for ahb_sram_responder: one instance with one wait state, one with none,
// expected responses queued at issue time and checked by a bus monitor.
module tb_ahb_sram_responder;

  typedef struct {
    int          which;
    logic        isRead;
    logic [31:0] rdata;
    logic        resp;
    int          lows;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [11:0] haddr;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic        hwrite;
  logic [31:0] hwdata;
  logic        hselV      [2];
  logic        hreadyoutV [2];
  logic        hrespV     [2];
  logic [31:0] hrdataV    [2];

  int   checks   = 0;
  int   failures = 0;
  exp_t expQ[$];
  exp_t monE;
  logic pending [2];
  int   lows    [2];
  logic lowResp [2];

  ahb_sram_responder #(.ADDR_W(12), .MEM_DEPTH(256), .WAIT_STATES(1)) dutWait (
    .clk(clk), .reset(reset), .hsel(hselV[1]), .haddr(haddr), .htrans(htrans),
    .hsize(hsize), .hwrite(hwrite), .hready(hreadyoutV[1]), .hwdata(hwdata),
    .hreadyout(hreadyoutV[1]), .hresp(hrespV[1]), .hrdata(hrdataV[1])
  );

  ahb_sram_responder #(.ADDR_W(12), .MEM_DEPTH(256), .WAIT_STATES(0)) dutFast (
    .clk(clk), .reset(reset), .hsel(hselV[0]), .haddr(haddr), .htrans(htrans),
    .hsize(hsize), .hwrite(hwrite), .hready(hreadyoutV[0]), .hwdata(hwdata),
    .hreadyout(hreadyoutV[0]), .hresp(hrespV[0]), .hrdata(hrdataV[0])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endfunction

  task automatic pushExp(input int which, input logic isRead, input logic [31:0] rdata,
                         input logic resp, input int nLows);
    exp_t e;
    e.which  = which;
    e.isRead = isRead;
    e.rdata  = rdata;
    e.resp   = resp;
    e.lows   = nLows;
    expQ.push_back(e);
  endtask

  // Non-pipelined transfer: address phase, then hold hwdata until the data phase ends.
  task automatic applyStimulus(input int which, input logic wr, input logic [2:0] sz,
                               input logic [11:0] addr, input logic [31:0] wdata,
                               input logic expResp, input int expLows,
                               input logic [31:0] expRdata);
    int n;
    pushExp(which, ~wr, expRdata, expResp, expLows);
    hselV[which] = 1'b1;
    htrans       = 2'd2;
    haddr        = addr;
    hsize        = sz;
    hwrite       = wr;
    @(posedge clk); #1;
    hselV[which] = 1'b0;
    htrans       = 2'd0;
    hwdata       = wdata;
    n = 0;
    while (!hreadyoutV[which] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("ready_timeout", 32'(hreadyoutV[which]), 32'd1);
    @(posedge clk); #1;
  endtask

  // Monitor: tracks each responder's data phase from the bus and scores completions.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic wasPending;
      wasPending = pending[d];
      if (wasPending && !hreadyoutV[d]) begin
        lows[d]++;
        lowResp[d] = lowResp[d] | hrespV[d];
        checkOutput("rdata_in_wait", hrdataV[d], 32'd0);
      end else if (wasPending) begin
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_completion dut=%0d actual=completion required=none", d);
        end else begin
          monE = expQ.pop_front();
          checkOutput("which_dut", 32'(d), 32'(monE.which));
          checkOutput("hresp", 32'(hrespV[d]), 32'(monE.resp));
          checkOutput("low_cycles", 32'(lows[d]), 32'(monE.lows));
          if (monE.lows > 0) checkOutput("hresp_first", 32'(lowResp[d]), 32'(monE.resp));
          if (monE.isRead) checkOutput("hrdata", hrdataV[d], monE.rdata);
        end
      end
      if (reset) begin
        pending[d] = 1'b0;
      end else if (!(wasPending && !hreadyoutV[d])) begin
        pending[d] = hselV[d] & hreadyoutV[d] & htrans[1];
        lows[d]    = 0;
        lowResp[d] = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset    = 1'b1;
    haddr    = 12'h000;
    htrans   = 2'd0;
    hsize    = 3'd0;
    hwrite   = 1'b0;
    hwdata   = 32'd0;
    for (int d = 0; d < 2; d++) begin
      hselV[d]   = 1'b0;
      pending[d] = 1'b0;
      lows[d]    = 0;
      lowResp[d] = 1'b0;
    end

    $display("[TB] reset and idle transfers");
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      checkOutput("reset_hreadyout", 32'(hreadyoutV[d]), 32'd1);
      checkOutput("reset_hresp", 32'(hrespV[d]), 32'd0);
      checkOutput("reset_hrdata", hrdataV[d], 32'd0);
    end
    reset    = 1'b0;
    hselV[1] = 1'b1;
    haddr    = 12'h010;
    htrans   = 2'd0;
    @(posedge clk); #1;
    checkOutput("idle_hreadyout", 32'(hreadyoutV[1]), 32'd1);
    checkOutput("idle_hresp", 32'(hrespV[1]), 32'd0);
    htrans = 2'd1;
    @(posedge clk); #1;
    checkOutput("busy_hreadyout", 32'(hreadyoutV[1]), 32'd1);
    checkOutput("busy_hresp", 32'(hrespV[1]), 32'd0);
    hselV[1] = 1'b0;
    htrans   = 2'd0;
    @(posedge clk); #1;

    $display("[TB] word write/read with one wait state");
    applyStimulus(1, 1'b1, 3'd2, 12'h010, 32'hDEADBEEF, 1'b0, 1, 32'd0);
    applyStimulus(1, 1'b0, 3'd2, 12'h010, 32'd0, 1'b0, 1, 32'hDEADBEEF);

    $display("[TB] byte and halfword lanes");
    applyStimulus(1, 1'b1, 3'd2, 12'h010, 32'h00000000, 1'b0, 1, 32'd0);
    applyStimulus(1, 1'b1, 3'd0, 12'h011, 32'h0000AA00, 1'b0, 1, 32'd0);
    applyStimulus(1, 1'b1, 3'd1, 12'h012, 32'h12340000, 1'b0, 1, 32'd0);
    applyStimulus(1, 1'b0, 3'd2, 12'h010, 32'd0, 1'b0, 1, 32'h1234AA00);

    $display("[TB] error responses");
    applyStimulus(1, 1'b0, 3'd1, 12'h003, 32'd0, 1'b1, 1, 32'd0);
    applyStimulus(1, 1'b1, 3'd2, 12'h400, 32'hFFFFFFFF, 1'b1, 1, 32'd0);
    applyStimulus(1, 1'b1, 3'd1, 12'h011, 32'hFFFFFFFF, 1'b1, 1, 32'd0);
    applyStimulus(1, 1'b1, 3'd3, 12'h010, 32'hFFFFFFFF, 1'b1, 1, 32'd0);
    applyStimulus(1, 1'b0, 3'd2, 12'h010, 32'd0, 1'b0, 1, 32'h1234AA00);

    $display("[TB] back-to-back with zero wait states");
    hselV[0] = 1'b1;
    htrans   = 2'd2;
    haddr    = 12'h020;
    hsize    = 3'd2;
    hwrite   = 1'b1;
    pushExp(0, 1'b0, 32'd0, 1'b0, 0);
    @(posedge clk); #1;
    checkOutput("b2b_write_ready", 32'(hreadyoutV[0]), 32'd1);
    hwrite = 1'b0;
    hwdata = 32'h11111111;
    pushExp(0, 1'b1, 32'h11111111, 1'b0, 0);
    @(posedge clk); #1;
    checkOutput("b2b_read_ready", 32'(hreadyoutV[0]), 32'd1);
    hselV[0] = 1'b0;
    htrans   = 2'd0;
    @(posedge clk); #1;

    $display("[TB] reset during a wait state");
    applyStimulus(1, 1'b1, 3'd2, 12'h030, 32'h0BADF00D, 1'b0, 1, 32'd0);
    hselV[1] = 1'b1;
    htrans   = 2'd2;
    haddr    = 12'h030;
    hsize    = 3'd2;
    hwrite   = 1'b1;
    @(posedge clk); #1;
    checkOutput("wait_before_reset", 32'(hreadyoutV[1]), 32'd0);
    hselV[1] = 1'b0;
    htrans   = 2'd0;
    hwdata   = 32'h55555555;
    reset    = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("midreset_hreadyout", 32'(hreadyoutV[1]), 32'd1);
    checkOutput("midreset_hresp", 32'(hrespV[1]), 32'd0);
    checkOutput("midreset_hrdata", hrdataV[1], 32'd0);
    @(posedge clk); #1;
    applyStimulus(1, 1'b0, 3'd2, 12'h030, 32'd0, 1'b0, 1, 32'h0BADF00D);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
